sram_req_ctrl: RTL and testbench

Synchronous request front-end that sits directly upstream of the single-port 1rw SRAM macro (16 words × 4 bits by default). It clears the array after reset, then converts a valid/ready request stream into the macro's csb0/web0/addr0/din0 port signals. It captures dout0 in the one-edge window where it is valid, and returns read data through a credit-protected response FIFO with valid/ready handshake.

---
 rtl/sram_ctrl_pkg.sv | 18 +
 rtl/sram_rsp_fifo.sv | 61 ++++++
 rtl/sram_req_ctrl.sv | 101 ++++++++++
 tb/tb_sram_req_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding, default widths and sizing helpers for the SRAM
// request front-end.
package sram_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    // Bits needed to hold a count in the range 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous read-response FIFO with occupancy output; an empty FIFO
// presents zero data and a push is visible only after its edge.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RSP_DEPTH  = 4,
    parameter int CNT_WIDTH  = credit_width(RSP_DEPTH)
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int PTR_WIDTH = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  do_pop;

    assign rsp_valid = (count != '0);
    assign do_pop    = pop && rsp_valid;
    assign rsp_rdata = rsp_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk0) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, do_pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk0) disable iff (rst0)
        !(push && !do_pop && (count == CNT_WIDTH'(RSP_DEPTH))));

endmodule

// File: rtl/sram_req_ctrl.sv
// Front-end for a single-port 1rw SRAM macro: clears the array after reset,
// then turns a valid/ready request stream into macro port cycles.
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int CNT_WIDTH = credit_width(RSP_DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);

    ctrl_state_e           state;
    logic [ADDR_WIDTH:0]   init_cnt;
    logic                  rd_s1;
    logic                  rd_s2;
    logic [CNT_WIDTH-1:0]  fifo_count;
    logic [CNT_WIDTH-1:0]  in_use;
    logic [CNT_WIDTH-1:0]  credits;
    logic                  req_fire;
    logic                  rsp_pop;

    // Every outstanding read owns a FIFO slot, so the FIFO cannot overflow.
    assign in_use    = fifo_count + CNT_WIDTH'(rd_s1) + CNT_WIDTH'(rd_s2);
    assign credits   = CNT_WIDTH'(RSP_DEPTH) - in_use;
    assign req_ready = (state == RUN) && (credits != '0);
    assign req_fire  = req_valid && req_ready;
    assign rsp_pop   = rsp_valid && rsp_ready;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state     <= INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            csb0      <= 1'b1;
            web0      <= 1'b1;
            addr0     <= '0;
            din0      <= '0;
            rd_s1     <= 1'b0;
            rd_s2     <= 1'b0;
        end else begin
            csb0  <= 1'b1;
            web0  <= 1'b1;
            rd_s1 <= 1'b0;
            rd_s2 <= rd_s1;
            if (state == INIT) begin
                csb0     <= 1'b0;
                web0     <= 1'b0;
                addr0    <= init_cnt[ADDR_WIDTH-1:0];
                din0     <= '0;
                init_cnt <= init_cnt + CNT_ONE;
                if (init_cnt == LAST_ADDR) begin
                    state     <= RUN;
                    init_done <= 1'b1;
                end
            end else if (req_fire) begin
                csb0  <= 1'b0;
                web0  <= !req_we;
                addr0 <= req_addr;
                din0  <= req_wdata;
                rd_s1 <= !req_we;
            end
        end
    end

    // dout0 is valid only around the edge two cycles after issue.
    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_rsp_fifo (
        .clk0      (clk0),
        .rst0      (rst0),
        .push      (rd_s2),
        .push_data (dout0),
        .pop       (rsp_pop),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl driving a behavioural 1rw SRAM macro
// (negedge write, DELAY read data, X after T_HOLD).
module tb_sram_req_ctrl;

    localparam int DW = 4;
    localparam int AW = 4;
    localparam int RD = 4;
    localparam int DEPTH = 16;
    localparam int DELAY = 3;
    localparam int T_HOLD = 1;

    logic clk0 = 1'b0;
    logic rst0 = 1'b1;
    logic req_valid = 1'b0;
    logic req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic rsp_ready = 1'b0;
    logic req_ready, rsp_valid, init_done, csb0, web0;
    logic [DW-1:0] rsp_rdata, din0, dout0;
    logic [AW-1:0] addr0;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int got_cyc[$];

    // clock / reset block
    always #5 clk0 = ~clk0;
    always @(posedge clk0) cyc <= cyc + 1;

    // macro model
    logic [DW-1:0] mem [DEPTH];
    logic csb_r = 1'b1;
    logic web_r = 1'b1;
    logic [AW-1:0] addr_r = '0;
    logic [DW-1:0] din_r = '0;

    initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i) | 4'h8;

    always @(posedge clk0) begin
        csb_r = csb0;
        web_r = web0;
        addr_r = addr0;
        din_r = din0;
        if (!csb0 && web0) dout0 <= #T_HOLD 'x;
    end

    always @(negedge clk0) begin
        if (!csb_r && !web_r) mem[addr_r] = din_r;
        if (!csb_r && web_r) dout0 <= #DELAY mem[addr_r];
    end

    // response monitor: records every handshake with its cycle stamp
    always @(negedge clk0) begin
        if (rsp_valid && rsp_ready) begin
            got_q.push_back(rsp_rdata);
            got_cyc.push_back(cyc);
        end
    end

    sram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RD)) dut (
        .clk0(clk0), .rst0(rst0),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int w = 0;
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        while (!req_ready && w < 50) begin
            step();
            w++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: req_ready=%b after %0d cycles, want 1", req_ready, w);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int w = 0;
        while (got_q.size() < n && w < 100) begin
            step();
            w++;
        end
        n_tests++;
        if (got_q.size() < n) begin
            n_fail++;
            $display("FAIL rsp_timeout: got %0d responses, want %0d", got_q.size(), n);
        end
    endtask

    // scenarios
    task automatic test_reset();
        rst0 = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        step();
        step();
        n_tests++;
        if ({csb0, web0, addr0, din0} !== {1'b1, 1'b1, 4'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_port: got csb0=%b web0=%b addr0=%h din0=%h, want 1 1 0 0", csb0, web0, addr0, din0);
        end
        n_tests++;
        if ({req_ready, rsp_valid, rsp_rdata, init_done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready=%b valid=%b rdata=%h done=%b, want all 0", req_ready, rsp_valid, rsp_rdata, init_done);
        end
    endtask

    task automatic test_init();
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = '0;
        rst0 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (req_ready !== 1'b0 || init_done !== 1'b0) begin
                n_fail++;
                $display("FAIL init_ready c%0d: got ready=%b done=%b, want 0 0", i, req_ready, init_done);
            end
            step();
            n_tests++;
            if ({csb0, web0, addr0, din0} !== {2'b00, AW'(i), DW'(0)}) begin
                n_fail++;
                $display("FAIL init_write c%0d: got csb0=%b web0=%b addr0=%h din0=%h, want 0 0 %h 0", i, csb0, web0, addr0, din0, AW'(i));
            end
        end
        n_tests++;
        if (init_done !== 1'b1 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done: got done=%b ready=%b, want 1 1", init_done, req_ready);
        end
    endtask

    task automatic test_init_reads();
        logic [DW-1:0] g, e;
        rsp_ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            send(1'b0, AW'(a), '0);
            exp_q.push_back('0);
        end
        wait_rsp(DEPTH);
        for (int i = 0; i < DEPTH && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL init_read a%0d: got %h want %h", i, g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        send(1'b1, 4'd3, 4'hA);
        send(1'b0, 4'd3, 4'h0);
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_rd_k1: got rsp_valid=%b want 0", rsp_valid);
        end
        step();
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_rd_k2: got rsp_valid=%b want 0", rsp_valid);
        end
        step();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 4'hA) begin
            n_fail++;
            $display("FAIL wr_rd_k3: got valid=%b rdata=%h want 1 a", rsp_valid, rsp_rdata);
        end
        step();
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== 4'hA) begin
            n_fail++;
            $display("FAIL wr_rd_once: got %0d responses, want exactly one of value a", got_q.size());
        end
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_back_to_back();
        int c0;
        logic [DW-1:0] g, e;
        rsp_ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) send(1'b1, AW'(a), DW'(a ^ 5));
        c0 = cyc;
        for (int a = 0; a < DEPTH; a++) begin
            send(1'b0, AW'(a), '0);
            exp_q.push_back(DW'(a ^ 5));
        end
        n_tests++;
        if (cyc - c0 != DEPTH) begin
            n_fail++;
            $display("FAIL b2b_issue: got %0d cycles for 16 reads, want 16", cyc - c0);
        end
        wait_rsp(DEPTH);
        for (int i = 1; i < got_cyc.size(); i++) begin
            n_tests++;
            if (got_cyc[i] - got_cyc[i-1] != 1) begin
                n_fail++;
                $display("FAIL b2b_bubble r%0d: got gap %0d want 1", i, got_cyc[i] - got_cyc[i-1]);
            end
        end
        for (int i = 0; i < DEPTH && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL b2b_data r%0d: got %h want %h", i, g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_backpressure();
        int a = 0;
        int acc = 0;
        logic [DW-1:0] g, e;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we = 1'b0;
        for (int c = 0; c < 12; c++) begin
            req_addr = AW'(a);
            if (req_ready) begin
                exp_q.push_back(DW'(a ^ 5));
                acc++;
                a++;
            end
            step();
        end
        req_valid = 1'b0;
        n_tests++;
        if (acc != RD) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d reads accepted, want %0d", acc, RD);
        end
        n_tests++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_stall: got ready=%b valid=%b popped=%0d, want 0 1 0", req_ready, rsp_valid, got_q.size());
        end
        rsp_ready = 1'b1;
        wait_rsp(RD);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_reready: got req_ready=%b want 1", req_ready);
        end
        for (int i = 0; i < RD && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL bp_data r%0d: got %h want %h", i, g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_toggle();
        logic [31:0] pat = 32'hB2D3_6C59;
        int sent = 0;
        int max_out = 0;
        logic [DW-1:0] g, e;
        req_we = 1'b0;
        for (int c = 0; c < 120 && sent < 20; c++) begin
            rsp_ready = pat[c % 32];
            req_valid = 1'b1;
            req_addr = AW'(sent);
            if (req_ready) begin
                exp_q.push_back(DW'((sent % 16) ^ 5));
                sent++;
            end
            step();
            if (sent - got_q.size() > max_out) max_out = sent - got_q.size();
        end
        req_valid = 1'b0;
        n_tests++;
        if (sent != 20) begin
            n_fail++;
            $display("FAIL tog_sent: got %0d reads accepted, want 20", sent);
        end
        n_tests++;
        if (max_out > RD) begin
            n_fail++;
            $display("FAIL tog_outstanding: got %0d outstanding, want <= %0d", max_out, RD);
        end
        rsp_ready = 1'b1;
        wait_rsp(20);
        for (int i = 0; i < 20 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL tog_data r%0d: got %h want %h", i, g, e);
            end
        end
        step();
        step();
        step();
        n_tests++;
        if (got_q.size() != 0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tog_extra: got %0d extra responses valid=%b, want 0 0", got_q.size(), rsp_valid);
        end
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] g;
        rsp_ready = 1'b0;
        send(1'b0, 4'd1, '0);
        send(1'b0, 4'd2, '0);
        send(1'b0, 4'd3, '0);
        send(1'b0, 4'd4, '0);
        rst0 = 1'b1;
        step();
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 4'h0 || csb0 !== 1'b1 || web0 !== 1'b1) begin
            n_fail++;
            $display("FAIL mrst_outputs: got valid=%b rdata=%h csb0=%b web0=%b, want 0 0 1 1", rsp_valid, rsp_rdata, csb0, web0);
        end
        n_tests++;
        if (req_ready !== 1'b0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mrst_ctrl: got ready=%b done=%b, want 0 0", req_ready, init_done);
        end
        rst0 = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            n_tests++;
            if ({csb0, web0, addr0} !== {2'b00, AW'(i)}) begin
                n_fail++;
                $display("FAIL mrst_init c%0d: got csb0=%b web0=%b addr0=%h, want 0 0 %h", i, csb0, web0, addr0, AW'(i));
            end
        end
        n_tests++;
        if (init_done !== 1'b1 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL mrst_done: got done=%b stale=%0d, want 1 0", init_done, got_q.size());
        end
        send(1'b0, 4'd3, '0);
        send(1'b0, 4'd10, '0);
        wait_rsp(2);
        for (int i = 0; i < 2 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            n_tests++;
            if (g !== 4'h0) begin
                n_fail++;
                $display("FAIL mrst_cleared r%0d: got %h want 0", i, g);
            end
        end
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        test_reset();
        test_init();
        test_init_reads();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_toggle();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
